// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the single regfile write port between NUM_REQ
// writeback sources. It picks one source per cycle (round-robin or fixed
// priority) and registers the winning write for one cycle. It also keeps
// a busy scoreboard of destination registers that still have a write in flight.
module wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*5-1:0]  req_rd,
  input  logic [NUM_REQ*32-1:0] req_data,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_rd,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic [31:0]           busy_vec
);

  localparam int PW = $clog2(NUM_REQ);
  typedef logic [PW-1:0] idx_t;

  idx_t               rr_ptr;
  idx_t               gnt_idx;
  idx_t               ptr_next;
  logic               gnt_any;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               xfer;
  logic [4:0]         sel_rd;
  logic [31:0]        sel_data;
  logic [31:0]        busy_next;

  // Arbitration: scan from rr_ptr (or from index 0) and take the first valid source.
  always_comb begin
    int idx;
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (FIXED_PRIO) idx = k;
      else            idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any         = 1'b1;
        gnt_idx         = idx_t'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

  // Grants are suppressed while reset is held, so nothing is accepted then.
  assign req_ready = {NUM_REQ{rst_n}} & gnt_onehot;
  assign xfer      = rst_n & gnt_any;
  assign ptr_next  = (gnt_idx == idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Select the destination and data of the granted source.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == idx_t'(i)) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  // Output stage and pointer. A write to x0 is consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      rr_ptr  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      wb_we <= xfer && (sel_rd != 5'd0);
      if (xfer) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
        if (!FIXED_PRIO) rr_ptr <= ptr_next;
      end
    end
  end

  // Scoreboard next state: clear on the committing write, then set on issue (set wins).
  always_comb begin
    busy_next = busy_vec;
    if (wb_we) busy_next[wb_rd] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= busy_next;
  end

endmodule
